// File: rtl/fnd_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit seven-segment scan back into digit codes,
// decimal points and a binary value, committing one frame per complete scan.
module fnd_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fndCom,
    input  logic [7:0]  fndFont,
    output logic [15:0] digits,
    output logic [3:0]  dpOut,
    output logic [13:0] value,
    output logic        frameValid,
    output logic        fontErr,
    output logic        scanLost
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {SCAN, COMMIT} state_t;

    state_t state, state_next;

    logic [3:0]        com_q, com_p;
    logic [7:0]        font_q, font_p;
    logic [7:0]        stable_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              com_valid, same, capture, lost_hit;
    logic [1:0]        slot;
    logic [3:0]        slot_bit;
    logic [3:0]        font_code;
    logic              font_bad;
    logic [3:0]        stage_digit [4];
    logic [3:0]        stage_dp, stage_err, mask;
    logic [13:0]       value_sum;

    function automatic logic [13:0] digit_val(input logic [3:0] d);
        return (d <= 4'd9) ? {10'd0, d} : 14'd0;
    endfunction

    always_comb begin
        com_valid = 1'b1;
        slot      = 2'd0;
        case (com_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: com_valid = 1'b0;
        endcase
    end

    assign slot_bit = 4'b0001 << slot;
    assign same     = (com_q == com_p) && (font_q == font_p);
    // Firing on the transition into STABLE_CYCLES-1 captures the pattern that was actually held.
    assign capture  = com_valid && same && (stable_cnt == 8'(STABLE_CYCLES - 2));
    assign lost_hit = !capture && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        font_code = 4'hE;
        font_bad  = 1'b0;
        case (font_q[6:0])
            7'h40:   font_code = 4'd0;
            7'h79:   font_code = 4'd1;
            7'h24:   font_code = 4'd2;
            7'h30:   font_code = 4'd3;
            7'h19:   font_code = 4'd4;
            7'h12:   font_code = 4'd5;
            7'h02:   font_code = 4'd6;
            7'h78:   font_code = 4'd7;
            7'h00:   font_code = 4'd8;
            7'h10:   font_code = 4'd9;
            7'h7F:   font_code = 4'hF;
            default: font_bad  = 1'b1;
        endcase
    end

    assign value_sum = 14'd1000 * digit_val(stage_digit[3])
                     + 14'd100  * digit_val(stage_digit[2])
                     + 14'd10   * digit_val(stage_digit[1])
                     + digit_val(stage_digit[0]);

    always_comb begin
        state_next = state;
        frameValid = 1'b0;
        case (state)
            SCAN:   if (mask == 4'hF) state_next = COMMIT;
            COMMIT: begin
                frameValid = 1'b1;
                state_next = SCAN;
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCAN;
            com_q      <= 4'hF;
            com_p      <= 4'hF;
            font_q     <= 8'hFF;
            font_p     <= 8'hFF;
            stable_cnt <= '0;
            idle_cnt   <= '0;
            scanLost   <= 1'b0;
        end else begin
            state  <= state_next;
            com_q  <= fndCom;
            font_q <= fndFont;
            com_p  <= com_q;
            font_p <= font_q;
            if (!com_valid || !same)
                stable_cnt <= '0;
            else if (stable_cnt != 8'hFF)
                stable_cnt <= stable_cnt + 8'd1;
            if (capture)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES))
                idle_cnt <= idle_cnt + 1'b1;
            if (capture)
                scanLost <= 1'b0;
            else if (lost_hit)
                scanLost <= 1'b1;
        end
    end

    // A capture landing in the COMMIT cycle seeds the next frame's mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask      <= '0;
            stage_dp  <= '0;
            stage_err <= '0;
            for (int i = 0; i < 4; i++) stage_digit[i] <= '0;
        end else begin
            if (state == COMMIT)
                mask <= capture ? slot_bit : 4'h0;
            else if (lost_hit)
                mask <= '0;
            else if (capture)
                mask <= mask | slot_bit;
            if (capture) begin
                stage_digit[slot] <= font_code;
                stage_dp[slot]    <= ~font_q[7];
                stage_err[slot]   <= font_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits  <= 16'hFFFF;
            dpOut   <= '0;
            value   <= '0;
            fontErr <= 1'b0;
        end else if (state_next == COMMIT) begin
            digits  <= {stage_digit[3], stage_digit[2], stage_digit[1], stage_digit[0]};
            dpOut   <= stage_dp;
            value   <= value_sum;
            fontErr <= |stage_err;
        end
    end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Randomized and directed bench for fnd_scan_decoder, checked against a frame-level
// reference model built from the scan/decode rules.
module tb_fnd_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;
    logic [15:0] digits;
    logic [3:0]  dpOut;
    logic [13:0] value;
    logic        frameValid, fontErr, scanLost;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [13:0] v;
        logic        e;
    } frame_t;

    frame_t obsQ[$];
    frame_t expQ[$];

    int checkCount = 0;
    int errorCount = 0;

    logic [3:0] mDigit [4];
    logic [3:0] mDp, mErr, mMask;
    logic [3:0] prevCom;
    logic [7:0] prevFont;
    int         runLen;
    bit         runCaptured;
    logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    fnd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .fndCom(fndCom), .fndFont(fndFont),
        .digits(digits), .dpOut(dpOut), .value(value),
        .frameValid(frameValid), .fontErr(fontErr), .scanLost(scanLost)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (frameValid) obsQ.push_back('{digits, dpOut, value, fontErr});

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit isValidCom(input logic [3:0] com);
        return $countones(~com) == 1;
    endfunction

    task automatic modelClear();
        mMask = '0; mDp = '0; mErr = '0;
        for (int i = 0; i < 4; i++) mDigit[i] = '0;
        prevCom = 4'hF; prevFont = 8'hFF; runLen = 0; runCaptured = 1'b0;
    endtask

    task automatic modelCapture(input logic [3:0] com, input logic [7:0] font);
        int slot, p, v;
        logic [3:0] code;
        logic err;
        frame_t f;
        slot = 0;
        for (int i = 0; i < 4; i++) if (!com[i]) slot = i;
        code = 4'hE; err = 1'b1;
        if (font[6:0] == 7'h7F) begin code = 4'hF; err = 1'b0; end
        for (int k = 0; k < 10; k++)
            if (font[6:0] == segTable[k]) begin code = 4'(k); err = 1'b0; end
        mDigit[slot] = code;
        mDp[slot]    = ~font[7];
        mErr[slot]   = err;
        mMask[slot]  = 1'b1;
        if (mMask == 4'hF) begin
            p = 1; v = 0;
            for (int i = 0; i < 4; i++) begin
                if (mDigit[i] <= 4'd9) v += int'(mDigit[i]) * p;
                p *= 10;
            end
            f.d  = {mDigit[3], mDigit[2], mDigit[1], mDigit[0]};
            f.dp = mDp;
            f.v  = 14'(v);
            f.e  = |mErr;
            expQ.push_back(f);
            mMask = '0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] com, input logic [7:0] font, input int len);
        fndCom  = com;
        fndFont = font;
        repeat (len) @(posedge clk);
        #1;
        if (com == prevCom && font == prevFont) runLen += len;
        else begin runLen = len; runCaptured = 1'b0; end
        prevCom = com; prevFont = font;
        if (isValidCom(com) && !runCaptured && runLen >= STABLE) begin
            modelCapture(com, font);
            runCaptured = 1'b1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1; fndCom = 4'hF; fndFont = 8'hFF;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        modelClear();
    endtask

    task automatic checkFrames(input string tag);
        int n;
        checkOutput($sformatf("%s frame count", tag), 64'(obsQ.size()), 64'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s frame %0d", tag, i), 64'(obsQ[i]), 64'(expQ[i]));
        obsQ.delete();
        expQ.delete();
    endtask

    function automatic logic [7:0] fontOf(input int d, input bit dp);
        return {~dp, segTable[d]};
    endfunction

    initial begin
        logic [3:0] com;
        logic [7:0] font;
        int r;
        doReset();
        checkOutput("reset digits", 64'(digits), 64'h FFFF);
        checkOutput("reset dpOut", 64'(dpOut), 64'h0);
        checkOutput("reset value", 64'(value), 64'h0);
        checkOutput("reset frameValid", 64'(frameValid), 64'h0);
        checkOutput("reset fontErr", 64'(fontErr), 64'h0);
        checkOutput("reset scanLost", 64'(scanLost), 64'h0);

        applyStimulus(4'hE, 8'hF9, 8);
        applyStimulus(4'hD, 8'hA4, 8);
        applyStimulus(4'hB, 8'hB0, 8);
        applyStimulus(4'h7, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("scan1234 pulses", 64'(obsQ.size()), 64'd1);
        checkOutput("scan1234 digits", 64'(digits), 64'h4321);
        checkOutput("scan1234 value", 64'(value), 64'd4321);
        checkOutput("scan1234 fontErr", 64'(fontErr), 64'h0);
        checkFrames("scan1234");

        applyStimulus(4'b1100, 8'hF9, 10);
        checkOutput("com1100 counter", 64'(dut.stable_cnt), 64'h0);
        applyStimulus(4'b1100, 8'hF9, 10);
        checkOutput("com1100 counter end", 64'(dut.stable_cnt), 64'h0);
        applyStimulus(4'b1111, 8'hA4, 20);
        checkOutput("com1111 counter", 64'(dut.stable_cnt), 64'h0);
        checkFrames("invalid com");

        doReset();
        applyStimulus(4'hE, 8'h40, 8);
        applyStimulus(4'hD, 8'hF9, 8);
        applyStimulus(4'hB, 8'hA4, 8);
        applyStimulus(4'h7, 8'hFF, 8);
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("blank digits", 64'(digits), 64'h F210);
        checkOutput("blank dpOut", 64'(dpOut), 64'h1);
        checkOutput("blank value", 64'(value), 64'd210);
        checkFrames("blank");

        doReset();
        applyStimulus(4'hE, 8'hC0, 8);
        applyStimulus(4'hD, 8'h5A, 8);
        applyStimulus(4'hB, 8'hB0, 8);
        applyStimulus(4'h7, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("bad font digits", 64'(digits), 64'h43E0);
        checkOutput("bad font fontErr", 64'(fontErr), 64'h1);
        checkOutput("bad font value", 64'(value), 64'd4300);
        checkFrames("bad font");

        doReset();
        applyStimulus(4'hE, 8'hF9, 8);
        applyStimulus(4'hD, 8'hA4, 8);
        doReset();
        applyStimulus(4'hE, 8'h90, 8);
        applyStimulus(4'hD, 8'h80, 8);
        applyStimulus(4'hB, 8'hF8, 8);
        applyStimulus(4'h7, 8'h82, 8);
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("reset midframe pulses", 64'(obsQ.size()), 64'd1);
        checkOutput("reset midframe digits", 64'(digits), 64'h6789);
        checkFrames("reset midframe");

        doReset();
        for (int i = 0; i < 300; i++)
            applyStimulus(~(4'b0001 << (i % 4)), fontOf(i % 10, 1'b0), 3);
        checkOutput("short holds not lost", 64'(scanLost), 64'h0);
        for (int i = 0; i < 70; i++)
            applyStimulus(~(4'b0001 << (i % 4)), fontOf((i + 3) % 10, 1'b0), 3);
        checkOutput("short holds lost", 64'(scanLost), 64'h1);
        checkOutput("lost digits held", 64'(digits), 64'h FFFF);
        applyStimulus(4'hE, fontOf(5, 1'b0), 8);
        checkOutput("lost cleared", 64'(scanLost), 64'h0);
        checkFrames("short holds");

        doReset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            com = (r < 17) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)       font = fontOf($urandom_range(0, 9), 1'($urandom));
            else if (r == 7) font = {1'($urandom), 7'h7F};
            else             font = 8'($urandom);
            applyStimulus(com, font, $urandom_range(1, 9));
        end
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("random scanLost", 64'(scanLost), 64'h0);
        checkFrames("random");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
